// File: rtl/mul_add_sub_arbiter.sv
// mul_add_sub_arbiter
//   Two-port round-robin arbiter and sequencer for a shared mulAddSub unit.
//   A job (a, b, c, op) is accepted from one requester, presented to the unit
//   with a single load strobe, held for LATENCY cycles, and the captured unit
//   result is returned with the requester ID over a valid/ready response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    job handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_c     signed operands: multiplier, multiplicand, addend
//   reqN_op                    1 = add c, 0 = subtract c
//   mas_load                   one-cycle load strobe to the unit
//   mas_multiplier/_multiplicand/_in3/_select   registered operands to the unit
//   mas_aluOut                 unit result (2*WIDTH bits)
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_data           requester ID and result of the finished job
module mul_add_sub_arbiter #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic signed [WIDTH-1:0]   req0_a,
  input  logic signed [WIDTH-1:0]   req0_b,
  input  logic signed [WIDTH-1:0]   req0_c,
  input  logic                      req0_op,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic signed [WIDTH-1:0]   req1_a,
  input  logic signed [WIDTH-1:0]   req1_b,
  input  logic signed [WIDTH-1:0]   req1_c,
  input  logic                      req1_op,
  output logic                      mas_load,
  output logic signed [WIDTH-1:0]   mas_multiplier,
  output logic signed [WIDTH-1:0]   mas_multiplicand,
  output logic signed [WIDTH-1:0]   mas_in3,
  output logic                      mas_select,
  input  logic signed [2*WIDTH-1:0] mas_aluOut,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic signed [2*WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_ptr;
  logic [3:0]                r_cnt;
  logic signed [WIDTH-1:0]   r_a;
  logic signed [WIDTH-1:0]   r_b;
  logic signed [WIDTH-1:0]   r_c;
  logic                      r_op;
  logic                      r_rsp_id;
  logic signed [2*WIDTH-1:0] r_rsp_data;

  logic w_any_vld;
  logic w_grant;
  logic w_grant_id;
  logic w_cnt_done;

  assign w_any_vld  = req0_valid | req1_valid;
  // Both valid: the pointer side wins; otherwise whichever one is valid.
  assign w_grant_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;
  // rst_n gates the grant so ready stays low while reset is held, even
  // though the state register already reads IDLE.
  assign w_grant    = rst_n & (r_state == IDLE) & w_any_vld;
  assign w_cnt_done = (r_cnt == 4'(LATENCY - 1));

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    mas_load    = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          req0_ready  = ~w_grant_id;
          req1_ready  = w_grant_id;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        mas_load    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_cnt_done) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_grant) r_ptr <= ~w_grant_id;
      if (r_state == LOAD)      r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 4'd1;
    end
  end

  // Operands change only at grant, so the unit sees them stable for the
  // whole job; the result is captured on the last WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_op       <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_grant) begin
        r_a      <= w_grant_id ? req1_a  : req0_a;
        r_b      <= w_grant_id ? req1_b  : req0_b;
        r_c      <= w_grant_id ? req1_c  : req0_c;
        r_op     <= w_grant_id ? req1_op : req0_op;
        r_rsp_id <= w_grant_id;
      end
      if ((r_state == WAIT) && w_cnt_done) r_rsp_data <= mas_aluOut;
    end
  end

  assign mas_multiplier   = r_a;
  assign mas_multiplicand = r_b;
  assign mas_in3          = r_c;
  assign mas_select       = r_op;
  assign rsp_id           = r_rsp_id;
  assign rsp_data         = r_rsp_data;

endmodule

// File: tb/tb_mul_add_sub_arbiter.sv
`timescale 1ns/1ps
// Bench for mul_add_sub_arbiter: two instances (LATENCY 4 and 1) driven from
// per-requester job queues, each with a stand-in mulAddSub unit, checked every
// cycle against a transaction-level model of the arbitration and timing rules.
module tb_mul_add_sub_arbiter;
  localparam int W    = 4;
  localparam int ND   = 2;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       op;
    logic [7:0] exp;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic v0 [ND];
  logic v1 [ND];
  logic r0 [ND];
  logic r1 [ND];
  logic ld [ND];
  logic sel [ND];
  logic rv [ND];
  logic rr [ND];
  logic rid [ND];
  logic op0 [ND];
  logic op1 [ND];
  logic [W-1:0] a0 [ND];
  logic [W-1:0] b0 [ND];
  logic [W-1:0] c0 [ND];
  logic [W-1:0] a1 [ND];
  logic [W-1:0] b1 [ND];
  logic [W-1:0] c1 [ND];
  logic [W-1:0] mm [ND];
  logic [W-1:0] mc [ND];
  logic [W-1:0] m3 [ND];
  logic [2*W-1:0] alu [ND];
  logic [2*W-1:0] rdat [ND];

  // a*b +/- c, truncated to 8-bit two's complement
  function automatic logic [7:0] f_ref(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic op);
    int ai, bi, ci, p;
    ai = $signed(a);
    bi = $signed(b);
    ci = $signed(c);
    p  = ai * bi;
    p  = op ? (p + ci) : (p - ci);
    return p[7:0];
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    mul_add_sub_arbiter #(.WIDTH(W), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0[g]), .req0_ready(r0[g]), .req0_a(a0[g]), .req0_b(b0[g]),
      .req0_c(c0[g]), .req0_op(op0[g]),
      .req1_valid(v1[g]), .req1_ready(r1[g]), .req1_a(a1[g]), .req1_b(b1[g]),
      .req1_c(c1[g]), .req1_op(op1[g]),
      .mas_load(ld[g]), .mas_multiplier(mm[g]), .mas_multiplicand(mc[g]),
      .mas_in3(m3[g]), .mas_select(sel[g]), .mas_aluOut(alu[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_id(rid[g]), .rsp_data(rdat[g])
    );
    // Stand-in unit: result is valid only in the LAT-th cycle after load and
    // later; before that it presents a value that never equals the result.
    int         ucnt = 0;
    logic [7:0] ures = 8'h00;
    always @(posedge clk) begin
      if (ld[g]) begin
        ucnt <= LAT;
        ures <= f_ref(mm[g], mc[g], m3[g], sel[g]);
      end else if (ucnt > 1) begin
        ucnt <= ucnt - 1;
      end
    end
    assign alu[g] = (ucnt == 1) ? ures : (~ures ^ 8'h5a);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  job_t q [ND][2][$];
  bit   en [ND][2];
  int   lat [ND];
  bit   m_busy [ND];
  int   m_acc [ND];
  job_t m_job [ND];
  bit   m_id [ND];
  bit   m_ptr [ND];
  logic [12:0] m_ops [ND];
  int   last_acc [ND];
  int   stall [ND];
  int   rsp_mode = 0;   // 0: always ready, 1: random, 2: hold low 5 cycles
  bit   rnd = 1'b0;
  bit   chk_period = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int d, input int r, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic op, input logic [7:0] exp);
    job_t j;
    j.a = a; j.b = b; j.c = c; j.op = op; j.exp = exp;
    q[d][r].push_back(j);
  endtask

  task automatic push_rand(input int d, input int r);
    logic [3:0] a, b, c;
    logic op;
    a  = 4'($urandom);
    b  = 4'($urandom);
    c  = 4'($urandom);
    op = 1'($urandom);
    push(d, r, a, b, c, op, f_ref(a, b, c, op));
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_busy[d]   = 1'b0;
      m_ptr[d]    = 1'b0;
      m_ops[d]    = '0;
      m_acc[d]    = 0;
      last_acc[d] = -1;
      stall[d]    = 0;
    end
  endtask

  task automatic check_reset();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ctl_d%0d", d), 32'({r0[d], r1[d], ld[d], rv[d]}), 32'd0);
      chk($sformatf("rst_ops_d%0d", d), 32'({mm[d], mc[d], m3[d], sel[d]}), 32'd0);
      chk($sformatf("rst_rsp_d%0d", d), 32'({rid[d], rdat[d]}), 32'd0);
    end
  endtask

  task automatic model(input int d);
    logic [3:0] ctl_e;
    bit gv, rv_e;
    int g;
    rv_e = m_busy[d] && (cyc >= m_acc[d] + 2 + lat[d]);
    gv   = !m_busy[d] && (v0[d] || v1[d]);
    g    = (v0[d] && v1[d]) ? int'(m_ptr[d]) : int'(v1[d]);
    if (m_busy[d]) ctl_e = {2'b00, cyc == m_acc[d] + 1, rv_e};
    else           ctl_e = {gv && g == 0, gv && g == 1, 2'b00};
    chk($sformatf("ctl_d%0d", d), 32'({r0[d], r1[d], ld[d], rv[d]}), 32'(ctl_e));
    chk($sformatf("ops_d%0d", d), 32'({mm[d], mc[d], m3[d], sel[d]}), 32'(m_ops[d]));
    if (rv_e)
      chk($sformatf("rsp_d%0d", d), 32'({rid[d], rdat[d]}), 32'({m_id[d], m_job[d].exp}));
    if (gv) begin
      m_job[d]  = q[d][g].pop_front();
      m_id[d]   = (g == 1);
      m_busy[d] = 1'b1;
      m_acc[d]  = cyc;
      m_ptr[d]  = (g == 0);
      m_ops[d]  = {m_job[d].a, m_job[d].b, m_job[d].c, m_job[d].op};
      if (chk_period && last_acc[d] >= 0)
        chk($sformatf("period_d%0d", d), 32'(cyc - last_acc[d]), 32'(lat[d] + 3));
      last_acc[d] = cyc;
    end else if (rv_e && rr[d]) begin
      m_busy[d] = 1'b0;
      stall[d]  = 0;
    end
  endtask

  task automatic cycle_body();
    bit rv_e;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (rnd) begin
          if (q[d][r].size() == 0 && $urandom_range(0, 3) == 0) push_rand(d, r);
          en[d][r] = ($urandom_range(0, 3) != 0);
        end else begin
          en[d][r] = 1'b1;
        end
      end
      v0[d] = en[d][0] && (q[d][0].size() != 0);
      v1[d] = en[d][1] && (q[d][1].size() != 0);
      if (q[d][0].size() != 0) begin
        a0[d] = q[d][0][0].a; b0[d] = q[d][0][0].b; c0[d] = q[d][0][0].c; op0[d] = q[d][0][0].op;
      end
      if (q[d][1].size() != 0) begin
        a1[d] = q[d][1][0].a; b1[d] = q[d][1][0].b; c1[d] = q[d][1][0].c; op1[d] = q[d][1][0].op;
      end
      rv_e = m_busy[d] && (cyc >= m_acc[d] + 2 + lat[d]);
      case (rsp_mode)
        0: rr[d] = 1'b1;
        1: rr[d] = 1'($urandom);
        default: begin
          if (rv_e) begin
            rr[d] = (stall[d] >= 5);
            stall[d]++;
          end else begin
            rr[d] = 1'($urandom);
          end
        end
      endcase
    end
    #1;
    for (int d = 0; d < ND; d++) model(d);
  endtask

  task automatic step();
    @(negedge clk);
    cycle_body();
  endtask

  function automatic bit drained();
    bit e;
    e = 1'b1;
    for (int d = 0; d < ND; d++)
      if (m_busy[d] || q[d][0].size() != 0 || q[d][1].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic run_drain(input int budget);
    for (int i = 0; i < budget && !drained(); i++) step();
    chk("drain", 32'(drained()), 32'd1);
  endtask

  // Reset pulled low mid-cycle; outputs must take reset values immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle_body();
  endtask

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    rst_n  = 1'b0;
    for (int d = 0; d < ND; d++) begin
      v0[d] = 0; v1[d] = 0; rr[d] = 0; op0[d] = 0; op1[d] = 0;
      a0[d] = 0; b0[d] = 0; c0[d] = 0; a1[d] = 0; b1[d] = 0; c1[d] = 0;
    end
    model_reset();
    @(negedge clk);
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle_body();

    // Requester 0 alone, then requester 1 alone
    for (int d = 0; d < ND; d++) push(d, 0, 4'd1, 4'd5, 4'd5, 1'b1, 8'h0A);
    run_drain(60);
    for (int d = 0; d < ND; d++) push(d, 1, 4'hB, 4'd5, 4'd5, 1'b1, 8'hEC);
    run_drain(60);

    // Both requesters contending from reset; grants alternate at full rate
    do_reset();
    chk_period = 1'b1;
    for (int d = 0; d < ND; d++) begin
      push(d, 0, 4'hB, 4'h9, 4'd5, 1'b0, 8'h1E);
      push(d, 1, 4'd6, 4'hA, 4'hC, 1'b1, 8'hD8);
      for (int k = 0; k < 3; k++) begin
        push_rand(d, 0);
        push_rand(d, 1);
      end
    end
    run_drain(200);
    chk_period = 1'b0;

    // Response back-pressure with both requesters waiting
    rsp_mode = 2;
    for (int d = 0; d < ND; d++) begin
      push_rand(d, 0);
      push_rand(d, 1);
    end
    run_drain(200);
    rsp_mode = 0;

    // Reset during WAIT discards the job; a fresh job then completes
    for (int d = 0; d < ND; d++) push_rand(d, 0);
    for (int i = 0; i < 50 && !(m_busy[0] && cyc == m_acc[0] + 3); i++) step();
    chk("reach_wait", 32'(m_busy[0] && cyc == m_acc[0] + 3), 32'd1);
    do_reset();
    for (int d = 0; d < ND; d++) begin
      q[d][0].delete();
      q[d][1].delete();
      push(d, 1, 4'h7, 4'h7, 4'h1, 1'b0, 8'h30);
    end
    run_drain(60);

    // Random traffic and response back-pressure
    rnd      = 1'b1;
    rsp_mode = 1;
    repeat (600) step();
    rnd = 1'b0;
    run_drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
